// File: rtl/sdram_arbiter2_if.sv
// Requester ports and controller bus of sdram_arbiter2, bundled as one interface.
// The master modport is the arbiter's view; slave is the requesters' and controller's view.
interface sdram_arbiter2_if #(
   parameter int unsigned c_addr_bits = 24
) ();
   logic                   p0_req;
   logic                   p0_we;
   logic [c_addr_bits-1:0] p0_addr;
   logic [15:0]            p0_wdata;
   logic [1:0]             p0_be;
   logic                   p0_ack;
   logic [15:0]            p0_rdata;

   logic                   p1_req;
   logic                   p1_we;
   logic [c_addr_bits-1:0] p1_addr;
   logic [15:0]            p1_wdata;
   logic [1:0]             p1_be;
   logic                   p1_ack;
   logic [15:0]            p1_rdata;

   logic                   mem_asn;
   logic                   mem_rw;
   logic                   mem_udsn;
   logic                   mem_ldsn;
   logic [c_addr_bits-1:0] mem_addr;
   logic [15:0]            mem_din;
   logic [15:0]            mem_dout;
   logic                   busy;

   modport master (
      input  p0_req, p0_we, p0_addr, p0_wdata, p0_be,
      output p0_ack, p0_rdata,
      input  p1_req, p1_we, p1_addr, p1_wdata, p1_be,
      output p1_ack, p1_rdata,
      output mem_asn, mem_rw, mem_udsn, mem_ldsn, mem_addr, mem_din,
      input  mem_dout,
      output busy
   );

   modport slave (
      output p0_req, p0_we, p0_addr, p0_wdata, p0_be,
      input  p0_ack, p0_rdata,
      output p1_req, p1_we, p1_addr, p1_wdata, p1_be,
      input  p1_ack, p1_rdata,
      input  mem_asn, mem_rw, mem_udsn, mem_ldsn, mem_addr, mem_din,
      output mem_dout,
      input  busy
   );
endinterface

// File: rtl/sdram_arbiter2.sv
// Two-port req/ack arbiter in front of the 68k-style SDRAM controller; each grant becomes one
// fixed-length strobe cycle followed by an ack pulse and an optional strobe-high gap.
module sdram_arbiter2 #(
   parameter int unsigned c_addr_bits     = 24,
   parameter int unsigned c_access_cycles = 8,
   parameter int unsigned c_gap_cycles    = 2,
   parameter int unsigned c_fixed_prio    = 0
) (
   input logic              clk,
   input logic              rst,
   sdram_arbiter2_if.master bus
);

   typedef enum logic [1:0] {StIdle, StAccess, StDone, StGap} state_e;

   localparam logic [7:0] AccessLoad = 8'(c_access_cycles - 1);
   localparam logic [7:0] GapLoad    = (c_gap_cycles == 0) ? 8'd0 : 8'(c_gap_cycles - 1);

   state_e                 state_q, state_d;
   logic [7:0]             cnt_q, cnt_d;
   logic                   gnt_q, gnt_d;
   logic                   last_q, last_d;
   logic                   mem_asn_q, mem_asn_d;
   logic                   mem_rw_q, mem_rw_d;
   logic                   mem_udsn_q, mem_udsn_d;
   logic                   mem_ldsn_q, mem_ldsn_d;
   logic [c_addr_bits-1:0] mem_addr_q, mem_addr_d;
   logic [15:0]            mem_din_q, mem_din_d;
   logic                   p0_ack_q, p0_ack_d;
   logic                   p1_ack_q, p1_ack_d;
   logic [15:0]            p0_rdata_q, p0_rdata_d;
   logic [15:0]            p1_rdata_q, p1_rdata_d;
   logic                   busy_q, busy_d;
   logic                   win;

   // Port chosen if a grant happens this cycle; only meaningful when some req is high.
   always_comb begin
      if (bus.p0_req && bus.p1_req) begin
         win = (c_fixed_prio != 0) ? 1'b0 : ~last_q;
      end else begin
         win = bus.p1_req;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      gnt_d      = gnt_q;
      last_d     = last_q;
      mem_asn_d  = mem_asn_q;
      mem_rw_d   = mem_rw_q;
      mem_udsn_d = mem_udsn_q;
      mem_ldsn_d = mem_ldsn_q;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      p0_ack_d   = 1'b0;
      p1_ack_d   = 1'b0;
      p0_rdata_d = p0_rdata_q;
      p1_rdata_d = p1_rdata_q;

      unique case (state_q)
         StIdle: begin
            if (bus.p0_req || bus.p1_req) begin
               state_d   = StAccess;
               cnt_d     = AccessLoad;
               gnt_d     = win;
               last_d    = win;
               mem_asn_d = 1'b0;
               if (win) begin
                  mem_rw_d   = ~bus.p1_we;
                  mem_udsn_d = ~bus.p1_be[1];
                  mem_ldsn_d = ~bus.p1_be[0];
                  mem_addr_d = bus.p1_addr;
                  mem_din_d  = bus.p1_wdata;
               end else begin
                  mem_rw_d   = ~bus.p0_we;
                  mem_udsn_d = ~bus.p0_be[1];
                  mem_ldsn_d = ~bus.p0_be[0];
                  mem_addr_d = bus.p0_addr;
                  mem_din_d  = bus.p0_wdata;
               end
            end
         end
         StAccess: begin
            if (cnt_q == 8'd0) begin
               state_d    = StDone;
               mem_asn_d  = 1'b1;
               mem_rw_d   = 1'b1;
               mem_udsn_d = 1'b1;
               mem_ldsn_d = 1'b1;
               // mem_rw_q still holds the direction of the access that is ending.
               if (gnt_q) begin
                  p1_ack_d = 1'b1;
                  if (mem_rw_q) p1_rdata_d = bus.mem_dout;
               end else begin
                  p0_ack_d = 1'b1;
                  if (mem_rw_q) p0_rdata_d = bus.mem_dout;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StDone: begin
            if (c_gap_cycles != 0) begin
               state_d = StGap;
               cnt_d   = GapLoad;
            end else begin
               state_d = StIdle;
            end
         end
         StGap: begin
            if (cnt_q == 8'd0) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= 8'd0;
         gnt_q      <= 1'b0;
         last_q     <= 1'b1;
         mem_asn_q  <= 1'b1;
         mem_rw_q   <= 1'b1;
         mem_udsn_q <= 1'b1;
         mem_ldsn_q <= 1'b1;
         mem_addr_q <= '0;
         mem_din_q  <= 16'h0000;
         p0_ack_q   <= 1'b0;
         p1_ack_q   <= 1'b0;
         p0_rdata_q <= 16'h0000;
         p1_rdata_q <= 16'h0000;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gnt_q      <= gnt_d;
         last_q     <= last_d;
         mem_asn_q  <= mem_asn_d;
         mem_rw_q   <= mem_rw_d;
         mem_udsn_q <= mem_udsn_d;
         mem_ldsn_q <= mem_ldsn_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         p0_ack_q   <= p0_ack_d;
         p1_ack_q   <= p1_ack_d;
         p0_rdata_q <= p0_rdata_d;
         p1_rdata_q <= p1_rdata_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.mem_asn  = mem_asn_q;
   assign bus.mem_rw   = mem_rw_q;
   assign bus.mem_udsn = mem_udsn_q;
   assign bus.mem_ldsn = mem_ldsn_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_din  = mem_din_q;
   assign bus.p0_ack   = p0_ack_q;
   assign bus.p1_ack   = p1_ack_q;
   assign bus.p0_rdata = p0_rdata_q;
   assign bus.p1_rdata = p1_rdata_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_sdram_arbiter2.sv
// Bench for sdram_arbiter2: a round-robin and a fixed-priority instance, driven by scenario tasks
// and checked against a transaction-level model of grants, strobe timing, acks and read data.
module tb_sdram_arbiter2;

   localparam int N = 8;
   localparam int G = 2;

   typedef struct packed {
      logic        timeout;
      int          wait_cycles;
      int          low;
      logic [23:0] addr;
      logic        rw;
      logic        udsn;
      logic        ldsn;
      logic [15:0] din;
      logic        stable;
      logic        ack0_done;
      logic        ack1_done;
      int          ack0_total;
      int          ack1_total;
      int          ack_early;
      logic [15:0] rdata0;
      logic [15:0] rdata1;
   } txn_obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   // Reference model state: round-robin pointer and expected read data per port.
   bit          rr_last = 1'b1;
   logic [15:0] exp_rdata [2];

   sdram_arbiter2_if #(.c_addr_bits(24)) rr ();
   sdram_arbiter2_if #(.c_addr_bits(24)) fx ();

   sdram_arbiter2 #(
      .c_addr_bits(24), .c_access_cycles(N), .c_gap_cycles(G), .c_fixed_prio(0)
   ) u_rr (
      .clk(clk), .rst(rst), .bus(rr.master)
   );

   sdram_arbiter2 #(
      .c_addr_bits(24), .c_access_cycles(N), .c_gap_cycles(G), .c_fixed_prio(1)
   ) u_fx (
      .clk(clk), .rst(rst), .bus(fx.master)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   function automatic bit model_winner(input bit r0, input bit r1, input bit fixed, input bit last);
      if (r0 && !r1) return 1'b0;
      if (r1 && !r0) return 1'b1;
      if (fixed) return 1'b0;
      return !last;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      rr.p0_req = 0; rr.p0_we = 0; rr.p0_addr = '0; rr.p0_wdata = '0; rr.p0_be = 2'b11;
      rr.p1_req = 0; rr.p1_we = 0; rr.p1_addr = '0; rr.p1_wdata = '0; rr.p1_be = 2'b11;
      rr.mem_dout = '0;
      fx.p0_req = 0; fx.p0_we = 0; fx.p0_addr = '0; fx.p0_wdata = '0; fx.p0_be = 2'b11;
      fx.p1_req = 0; fx.p1_we = 0; fx.p1_addr = '0; fx.p1_wdata = '0; fx.p1_be = 2'b11;
      fx.mem_dout = '0;
   endtask

   // Runs one single-port transaction on the round-robin instance and records what the bus did.
   task automatic run_txn(input bit port, input bit we, input logic [23:0] addr,
                          input logic [15:0] wdata, input logic [1:0] be,
                          input logic [15:0] dout, input int drop_after, output txn_obs_t o);
      int guard;
      o = '0;
      rr.mem_dout = dout;
      if (!port) begin
         rr.p0_we = we; rr.p0_addr = addr; rr.p0_wdata = wdata; rr.p0_be = be; rr.p0_req = 1;
      end else begin
         rr.p1_we = we; rr.p1_addr = addr; rr.p1_wdata = wdata; rr.p1_be = be; rr.p1_req = 1;
      end
      guard = 0;
      do begin
         tick();
         o.wait_cycles = o.wait_cycles + 1;
         guard++;
      end while (rr.mem_asn && guard < 40);
      if (rr.mem_asn) begin
         o.timeout = 1'b1;
         rr.p0_req = 0; rr.p1_req = 0;
         return;
      end
      rr_last = port;
      o.addr = rr.mem_addr; o.rw = rr.mem_rw; o.udsn = rr.mem_udsn; o.ldsn = rr.mem_ldsn;
      o.din = rr.mem_din; o.stable = 1'b1; o.low = 1;
      if (drop_after == 1) begin rr.p0_req = 0; rr.p1_req = 0; end
      guard = 0;
      while (guard < 300) begin
         tick();
         guard++;
         if (rr.mem_asn) break;
         o.low++;
         if (rr.mem_addr !== o.addr || rr.mem_rw !== o.rw || rr.mem_udsn !== o.udsn ||
             rr.mem_ldsn !== o.ldsn || rr.mem_din !== o.din) o.stable = 1'b0;
         if (rr.p0_ack || rr.p1_ack) o.ack_early++;
         if (o.low == drop_after) begin rr.p0_req = 0; rr.p1_req = 0; end
      end
      if (!rr.mem_asn) o.timeout = 1'b1;
      o.ack0_done = rr.p0_ack; o.ack1_done = rr.p1_ack;
      o.rdata0 = rr.p0_rdata; o.rdata1 = rr.p1_rdata;
      o.ack0_total = o.ack0_total + int'(rr.p0_ack);
      o.ack1_total = o.ack1_total + int'(rr.p1_ack);
      rr.p0_req = 0; rr.p1_req = 0;
      guard = 0;
      while (rr.busy && guard < 40) begin
         tick();
         guard++;
         o.ack0_total = o.ack0_total + int'(rr.p0_ack);
         o.ack1_total = o.ack1_total + int'(rr.p1_ack);
      end
      if (rr.busy) o.timeout = 1'b1;
      if (!we) exp_rdata[port] = dout;
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1;
      repeat (2) tick();
      checks++;
      if ({rr.mem_asn, rr.mem_rw, rr.mem_udsn, rr.mem_ldsn} !== 4'hF)
         $display("FAIL reset_strobes: got %b expected 1111",
                  {rr.mem_asn, rr.mem_rw, rr.mem_udsn, rr.mem_ldsn});
      if ({rr.mem_asn, rr.mem_rw, rr.mem_udsn, rr.mem_ldsn} !== 4'hF) errors++;
      checks++;
      if (rr.mem_addr !== 24'h0 || rr.mem_din !== 16'h0) begin
         errors++;
         $display("FAIL reset_addr_din: got %h/%h expected 000000/0000", rr.mem_addr, rr.mem_din);
      end
      checks++;
      if ({rr.p0_ack, rr.p1_ack, rr.busy} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ack_busy: got %b expected 000", {rr.p0_ack, rr.p1_ack, rr.busy});
      end
      checks++;
      if (rr.p0_rdata !== 16'h0 || rr.p1_rdata !== 16'h0) begin
         errors++;
         $display("FAIL reset_rdata: got %h/%h expected 0000/0000", rr.p0_rdata, rr.p1_rdata);
      end
      checks++;
      if ({fx.mem_asn, fx.busy} !== 2'b10) begin
         errors++;
         $display("FAIL reset_fx: got %b expected 10", {fx.mem_asn, fx.busy});
      end
      @(negedge clk);
      rst = 0;
      rr_last = 1'b1;
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
      tick();
   endtask

   task automatic test_read();
      txn_obs_t o;
      run_txn(1'b0, 1'b0, 24'h000123, 16'h0000, 2'b11, 16'hBEEF, 0, o);
      checks++;
      if (o.timeout !== 1'b0 || o.wait_cycles !== 1) begin
         errors++;
         $display("FAIL read_latency: got timeout=%0d wait=%0d expected 0/1", o.timeout,
                  o.wait_cycles);
      end
      checks++;
      if (o.low !== N) begin
         errors++; $display("FAIL read_strobe_len: got %0d expected %0d", o.low, N);
      end
      checks++;
      if (o.addr !== 24'h000123 || {o.rw, o.udsn, o.ldsn} !== 3'b100 || o.stable !== 1'b1) begin
         errors++;
         $display("FAIL read_fields: got addr=%h ctl=%b stable=%b expected 000123/100/1",
                  o.addr, {o.rw, o.udsn, o.ldsn}, o.stable);
      end
      checks++;
      if ({o.ack0_done, o.ack1_done} !== 2'b10 || o.ack0_total !== 1 || o.ack1_total !== 0 ||
          o.ack_early !== 0) begin
         errors++;
         $display("FAIL read_ack: got done=%b totals=%0d/%0d early=%0d expected 10 1/0 0",
                  {o.ack0_done, o.ack1_done}, o.ack0_total, o.ack1_total, o.ack_early);
      end
      checks++;
      if (o.rdata0 !== 16'hBEEF) begin
         errors++; $display("FAIL read_rdata: got %h expected beef", o.rdata0);
      end
   endtask

   task automatic test_write();
      txn_obs_t o;
      run_txn(1'b1, 1'b1, 24'h00FFFE, 16'hA55A, 2'b01, 16'h1234, 0, o);
      checks++;
      if (o.timeout !== 1'b0 || o.low !== N) begin
         errors++;
         $display("FAIL write_strobe_len: got timeout=%0d low=%0d expected 0/%0d", o.timeout,
                  o.low, N);
      end
      checks++;
      if (o.addr !== 24'h00FFFE || {o.rw, o.udsn, o.ldsn} !== 3'b010 || o.din !== 16'hA55A ||
          o.stable !== 1'b1) begin
         errors++;
         $display("FAIL write_fields: got addr=%h ctl=%b din=%h stable=%b expected 00fffe/010/a55a/1",
                  o.addr, {o.rw, o.udsn, o.ldsn}, o.din, o.stable);
      end
      checks++;
      if ({o.ack0_done, o.ack1_done} !== 2'b01 || o.ack0_total !== 0 || o.ack1_total !== 1) begin
         errors++;
         $display("FAIL write_ack: got done=%b totals=%0d/%0d expected 01 0/1",
                  {o.ack0_done, o.ack1_done}, o.ack0_total, o.ack1_total);
      end
      checks++;
      if (o.rdata1 !== exp_rdata[1] || o.rdata0 !== exp_rdata[0]) begin
         errors++;
         $display("FAIL write_rdata_kept: got %h/%h expected %h/%h", o.rdata0, o.rdata1,
                  exp_rdata[0], exp_rdata[1]);
      end
   endtask

   task automatic test_random();
      txn_obs_t    o;
      bit          port, we;
      logic [23:0] addr;
      logic [15:0] wdata, dout;
      logic [1:0]  be;
      for (int i = 0; i < 24; i++) begin
         port  = 1'($urandom_range(0, 1));
         we    = 1'($urandom_range(0, 1));
         addr  = 24'($urandom);
         wdata = 16'($urandom);
         dout  = 16'($urandom);
         be    = 2'($urandom_range(0, 3));
         run_txn(port, we, addr, wdata, be, dout, int'($urandom_range(0, 3)), o);
         checks++;
         if (o.timeout !== 1'b0 || o.low !== N || o.stable !== 1'b1) begin
            errors++;
            $display("FAIL rand_strobe[%0d]: got timeout=%0d low=%0d stable=%b expected 0/%0d/1",
                     i, o.timeout, o.low, o.stable, N);
         end
         checks++;
         if (o.addr !== addr || {o.rw, o.udsn, o.ldsn} !== {!we, !be[1], !be[0]} ||
             (we && o.din !== wdata)) begin
            errors++;
            $display("FAIL rand_fields[%0d]: got addr=%h ctl=%b din=%h expected %h/%b/%h", i,
                     o.addr, {o.rw, o.udsn, o.ldsn}, o.din, addr, {!we, !be[1], !be[0]}, wdata);
         end
         checks++;
         if (o.ack0_total !== (port ? 0 : 1) || o.ack1_total !== (port ? 1 : 0) ||
             o.ack_early !== 0 || o.ack1_done !== port) begin
            errors++;
            $display("FAIL rand_ack[%0d]: got totals=%0d/%0d early=%0d expected port %0d only",
                     i, o.ack0_total, o.ack1_total, o.ack_early, port);
         end
         checks++;
         if (o.rdata0 !== exp_rdata[0] || o.rdata1 !== exp_rdata[1]) begin
            errors++;
            $display("FAIL rand_rdata[%0d]: got %h/%h expected %h/%h", i, o.rdata0, o.rdata1,
                     exp_rdata[0], exp_rdata[1]);
         end
      end
   endtask

   task automatic test_drop_be0();
      txn_obs_t    o;
      logic [15:0] d0, d1;
      d0 = 16'($urandom);
      d1 = 16'($urandom);
      run_txn(1'b0, 1'b0, 24'h00_4000, 16'h0, 2'b11, d0, 2, o);
      checks++;
      if (o.timeout !== 1'b0 || o.low !== N || o.ack0_total !== 1 || o.ack1_total !== 0 ||
          o.rdata0 !== d0) begin
         errors++;
         $display("FAIL drop_req: got low=%0d acks=%0d/%0d rdata=%h expected %0d 1/0 %h",
                  o.low, o.ack0_total, o.ack1_total, o.rdata0, N, d0);
      end
      run_txn(1'b1, 1'b0, 24'h00_4002, 16'h0, 2'b00, d1, 0, o);
      checks++;
      if (o.timeout !== 1'b0 || o.low !== N || {o.udsn, o.ldsn} !== 2'b11 ||
          o.stable !== 1'b1) begin
         errors++;
         $display("FAIL be00_strobes: got low=%0d ds=%b stable=%b expected %0d/11/1", o.low,
                  {o.udsn, o.ldsn}, o.stable, N);
      end
      checks++;
      if (o.ack1_total !== 1 || o.ack0_total !== 0 || o.rdata1 !== d1) begin
         errors++;
         $display("FAIL be00_ack: got acks=%0d/%0d rdata=%h expected 0/1 %h", o.ack0_total,
                  o.ack1_total, o.rdata1, d1);
      end
   endtask

   task automatic test_rr_alternate();
      logic [23:0] a0, a1;
      logic [15:0] dv;
      logic        prev;
      bit          got, exp, cur;
      int          grants, hr, guard, acks;
      a0 = 24'($urandom) & 24'hFFFFFE;
      a1 = a0 | 24'h1;
      dv = 16'($urandom);
      rr.mem_dout = dv;
      rr.p0_we = 0; rr.p0_addr = a0; rr.p0_be = 2'b11;
      rr.p1_we = 0; rr.p1_addr = a1; rr.p1_be = 2'b11;
      rr.p0_req = 1; rr.p1_req = 1;
      prev = 1'b1; cur = 1'b0; grants = 0; hr = 0; guard = 0; acks = 0;
      while (guard < 600 && !(grants == 8 && !rr.busy)) begin
         tick();
         guard++;
         if (prev && !rr.mem_asn) begin
            got = (rr.mem_addr == a1);
            exp = model_winner(1'b1, 1'b1, 1'b0, rr_last);
            checks++;
            if (got !== exp) begin
               errors++; $display("FAIL rr_order[%0d]: got p%0d expected p%0d", grants, got, exp);
            end
            if (grants > 0) begin
               checks++;
               if (hr < G + 1) begin
                  errors++; $display("FAIL rr_gap[%0d]: got %0d expected >= %0d", grants, hr, G + 1);
               end
            end
            rr_last = exp;
            cur = got;
            hr = 0;
            grants++;
            if (grants == 8) begin rr.p0_req = 0; rr.p1_req = 0; end
         end else if (rr.mem_asn) begin
            hr++;
         end
         if (rr.p0_ack || rr.p1_ack) begin
            acks++;
            checks++;
            if (rr.p0_ack === rr.p1_ack || rr.p1_ack !== cur) begin
               errors++;
               $display("FAIL rr_ack: got acks=%b expected only p%0d", {rr.p1_ack, rr.p0_ack}, cur);
            end
         end
         prev = rr.mem_asn;
      end
      rr.p0_req = 0; rr.p1_req = 0;
      checks++;
      if (grants !== 8 || acks !== 8 || rr.busy !== 1'b0) begin
         errors++;
         $display("FAIL rr_total: got grants=%0d acks=%0d busy=%b expected 8/8/0", grants, acks,
                  rr.busy);
      end
      exp_rdata[0] = dv;
      exp_rdata[1] = dv;
      checks++;
      if (rr.p0_rdata !== dv || rr.p1_rdata !== dv) begin
         errors++;
         $display("FAIL rr_rdata: got %h/%h expected %h", rr.p0_rdata, rr.p1_rdata, dv);
      end
   endtask

   task automatic test_fixed_prio();
      logic [23:0] a0, a1;
      logic        prev;
      bit          r0, r1, got, exp, cur;
      int          grants, guard, p0_acks, p1_acks;
      a0 = 24'($urandom) & 24'hFFFFFE;
      a1 = a0 | 24'h1;
      fx.p0_we = 1; fx.p0_addr = a0; fx.p0_wdata = 16'($urandom); fx.p0_be = 2'b11;
      fx.p1_we = 1; fx.p1_addr = a1; fx.p1_wdata = 16'($urandom); fx.p1_be = 2'b11;
      r0 = 1; r1 = 1;
      fx.p0_req = 1; fx.p1_req = 1;
      prev = 1'b1; cur = 1'b0; grants = 0; guard = 0; p0_acks = 0; p1_acks = 0;
      while (guard < 600 && !(grants == 6 && !fx.busy)) begin
         tick();
         guard++;
         if (prev && !fx.mem_asn) begin
            got = (fx.mem_addr == a1);
            exp = model_winner(r0, r1, 1'b1, 1'b0);
            checks++;
            if (got !== exp) begin
               errors++; $display("FAIL fx_order[%0d]: got p%0d expected p%0d", grants, got, exp);
            end
            cur = got;
            grants++;
            if (grants == 5) begin r0 = 0; fx.p0_req = 0; end
            if (grants == 6) begin r1 = 0; fx.p1_req = 0; end
         end
         if (fx.p0_ack || fx.p1_ack) begin
            if (fx.p0_ack) p0_acks++;
            if (fx.p1_ack) p1_acks++;
            checks++;
            if (fx.p0_ack === fx.p1_ack || fx.p1_ack !== cur) begin
               errors++;
               $display("FAIL fx_ack: got acks=%b expected only p%0d", {fx.p1_ack, fx.p0_ack}, cur);
            end
         end
         prev = fx.mem_asn;
      end
      fx.p0_req = 0; fx.p1_req = 0;
      checks++;
      if (grants !== 6 || p0_acks !== 5 || p1_acks !== 1 || fx.busy !== 1'b0) begin
         errors++;
         $display("FAIL fx_total: got grants=%0d acks=%0d/%0d busy=%b expected 6 5/1 0", grants,
                  p0_acks, p1_acks, fx.busy);
      end
   endtask

   task automatic test_reset_mid_access();
      logic [23:0] a0, a1;
      logic [15:0] dv;
      bit          got, exp, ack_seen;
      int          guard;
      a0 = 24'($urandom) & 24'hFFFFFE;
      a1 = a0 | 24'h1;
      dv = 16'($urandom);
      rr.mem_dout = dv;
      rr.p0_we = 0; rr.p0_addr = a0; rr.p0_be = 2'b11;
      rr.p1_we = 0; rr.p1_addr = a1; rr.p1_be = 2'b11;
      rr.p0_req = 1; rr.p1_req = 1;
      guard = 0;
      do begin tick(); guard++; end while (rr.mem_asn && guard < 40);
      repeat (3) tick();
      checks++;
      if (rr.mem_asn !== 1'b0) begin
         errors++; $display("FAIL rst_pre_asn: got %b expected 0", rr.mem_asn);
      end
      rst = 1;
      #1;
      checks++;
      if ({rr.mem_asn, rr.mem_rw, rr.mem_udsn, rr.mem_ldsn} !== 4'hF) begin
         errors++;
         $display("FAIL rst_async_strobes: got %b expected 1111",
                  {rr.mem_asn, rr.mem_rw, rr.mem_udsn, rr.mem_ldsn});
      end
      ack_seen = 0;
      repeat (3) begin
         tick();
         if (rr.p0_ack || rr.p1_ack) ack_seen = 1;
      end
      checks++;
      if (ack_seen !== 1'b0 || rr.busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_no_ack: got ack_seen=%b busy=%b expected 0/0", ack_seen, rr.busy);
      end
      @(negedge clk);
      rst = 0;
      rr_last = 1'b1;
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
      #1;
      checks++;
      if (rr.busy !== 1'b0 || rr.p0_rdata !== 16'h0 || rr.p1_rdata !== 16'h0) begin
         errors++;
         $display("FAIL rst_release: got busy=%b rdata=%h/%h expected 0 0000/0000", rr.busy,
                  rr.p0_rdata, rr.p1_rdata);
      end
      guard = 0;
      do begin tick(); guard++; end while (rr.mem_asn && guard < 40);
      got = (rr.mem_addr == a1);
      exp = model_winner(1'b1, 1'b1, 1'b0, rr_last);
      checks++;
      if (rr.mem_asn !== 1'b0 || got !== exp) begin
         errors++;
         $display("FAIL rst_first_tie: got asn=%b p%0d expected asn=0 p%0d", rr.mem_asn, got, exp);
      end
      rr_last = exp;
      rr.p0_req = 0; rr.p1_req = 0;
      guard = 0;
      while (rr.busy && guard < 60) begin tick(); guard++; end
      checks++;
      if (rr.busy !== 1'b0) begin
         errors++; $display("FAIL rst_final_idle: got busy=%b expected 0", rr.busy);
      end
      exp_rdata[exp] = dv;
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_random();
      test_drop_be0();
      test_rr_alternate();
      test_fixed_prio();
      test_reset_mid_access();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sdram_arbiter2.md
Name: sdram_arbiter2

Overview:
- Two-port arbiter and sequencer in front of the 100 MHz SDRAM controller, which has a 68k-style interface (asn/rw/udsn/ldsn, 16-bit din/dout).
- Shares the controller between two requesters, for example the SPI loader and a CPU or video fetcher.
- Each port uses a simple req/ack handshake. The block turns each granted request into one timed bus cycle on the controller.
- It lives in the clk_sdram domain. Requesters in other domains synchronise before connecting.

Parameters:
- c_addr_bits, 24: word address width on both ports and on the controller.
- c_access_cycles, 8: cycles mem_asn is held low per access, range 2..255.
- c_gap_cycles, 2: minimum mem_asn-high cycles after an ack before the next grant, range 0..15.
- c_fixed_prio, 0: 0 = round-robin arbitration; 1 = port 0 always wins ties.

Ports:
- clk, in, 1: system clock (clk_sdram).
- rst, in, 1: asynchronous active-high reset.
- p0_req, in, 1: port 0 request, level.
- p0_we, in, 1: 1 = write, 0 = read.
- p0_addr, in, c_addr_bits: word address.
- p0_wdata, in, 16: write data.
- p0_be, in, 2: byte enables; [1] = upper byte, [0] = lower byte.
- p0_ack, out, 1: one-cycle completion pulse.
- p0_rdata, out, 16: read data.
- p1_req, p1_we, p1_addr, p1_wdata, p1_be, p1_ack, p1_rdata: same as port 0, for port 1.
- mem_asn, out, 1: address strobe, active low.
- mem_rw, out, 1: 1 = read, 0 = write.
- mem_udsn, out, 1: upper data strobe, active low.
- mem_ldsn, out, 1: lower data strobe, active low.
- mem_addr, out, c_addr_bits: address to the controller.
- mem_din, out, 16: write data to the controller.
- mem_dout, in, 16: read data from the controller.
- busy, out, 1: high whenever the state is not IDLE.

Behaviour:
- Reset is asynchronous and active-high, named rst; it takes effect immediately. Register values under reset:
  - mem_asn = 1, mem_rw = 1, mem_udsn = 1, mem_ldsn = 1.
  - mem_addr = 0, mem_din = 0.
  - p0_ack = 0, p1_ack = 0; p0_rdata = 0, p1_rdata = 0; busy = 0.
  - state = IDLE; round-robin pointer "last" = 1, so port 0 wins the first tie.
- All outputs are registered.
- Handshake:
  - A requester raises req with we/addr/wdata/be stable and holds them until it sees ack.
  - A req still high in the cycle after ack counts as a new request.
  - If req drops mid-access, the access still completes and ack still pulses.
- State machine: IDLE -> ACCESS -> DONE -> GAP -> IDLE.
- IDLE:
  - If any req is high at a clock edge, grant and enter ACCESS.
  - The winner's fields are latched into mem_addr, mem_din, mem_rw = ~we, and mem_udsn/mem_ldsn = ~be.
  - mem_asn goes to 0 and the counter loads c_access_cycles-1.
- Arbitration:
  - One requester: it wins.
  - Both requesting, c_fixed_prio = 1: port 0 wins.
  - Both requesting, c_fixed_prio = 0: the port not equal to "last" wins; "last" updates on every grant.
- ACCESS:
  - mem_asn = 0 for exactly c_access_cycles cycles; all mem_* fields stay stable.
  - The counter decrements. When it reaches 0, the next edge enters DONE.
  - On that same edge, mem_dout is captured into the granted port's rdata, but only for reads.
- DONE: one cycle.
  - The granted port's ack = 1.
  - mem_asn = mem_udsn = mem_ldsn = 1 and mem_rw = 1.
  - rdata is valid from this cycle and holds until that port's next read completes. Writes leave rdata unchanged.
  - Next state is GAP if c_gap_cycles > 0, otherwise IDLE.
- GAP: strobes stay high for c_gap_cycles cycles, then IDLE.
- Latency: req seen high at edge E0 gives mem_asn low in cycles 1..N (N = c_access_cycles) and ack in cycle N+1. The next grant happens no earlier than the edge at the end of cycle N+1+G (G = c_gap_cycles).
- Byte enables: be = 2'b00 still runs a full bus cycle with both data strobes high, and still acks. No port ever sees an ack it was not granted, and ack is never asserted for both ports at once.
- Reset during ACCESS: strobes go high immediately, no ack is issued, and the in-flight request is dropped. Requesters re-issue after reset.

Test Plan:
- Reset, then p0 read at addr 0x000123 with N=8, G=2 -> mem_asn low for exactly 8 cycles with mem_addr = 0x000123, mem_rw = 1, udsn = ldsn = 0; p0_ack pulses once at cycle 9; p0_rdata = mem_dout value 0xBEEF.
- p1 write of 0xA55A at 0x00FFFE with be = 2'b01 -> mem_rw = 0, mem_udsn = 1, mem_ldsn = 0, mem_din = 0xA55A for the whole strobe; p1_ack pulses once; p1_rdata unchanged.
- Both req held continuously, c_fixed_prio = 0 -> grants alternate p0, p1, p0, p1. Strobes stay high for at least 3 cycles between accesses (DONE plus 2 GAP). No ack overlaps.
- Both req held, c_fixed_prio = 1 -> p0 is granted every cycle; p1 is starved until p0_req drops, then p1 is granted at the next IDLE.
- Assert rst in the 4th ACCESS cycle -> mem_asn = 1 in the same cycle (async); acks stay 0; after release, busy = 0 and the first tie goes to p0.
- p0 drops req after 2 ACCESS cycles, and a be = 00 request is issued -> each access still completes its full 8 cycles and acks once. For be = 00, udsn = ldsn = 1 throughout.
